// File: rtl/sent_rx_frame_ctrl.sv
// SENT receive frame controller: buffers fast-channel words per frame, commits or
// discards them on the CRC verdict, holds slow messages, tracks errors and timeouts.
module sent_rx_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned DEPTH       = 4
) (
  input  logic        clk_rx,
  input  logic        reset_n_rx,
  input  logic        start_i,
  input  logic        wr_en_i,
  input  logic [11:0] wr_data_i,
  input  logic [2:0]  done_pre_data_i,
  input  logic        crc_valid_i,
  input  logic        crc_ok_i,
  input  logic [7:0]  slow_id_i,
  input  logic [15:0] slow_data_i,
  output logic        fast_valid_o,
  output logic [11:0] fast_data_o,
  input  logic        fast_ready_i,
  output logic        slow_valid_o,
  output logic [7:0]  slow_id_o,
  output logic [15:0] slow_data_o,
  input  logic        slow_ready_i,
  output logic [7:0]  crc_err_cnt_o,
  output logic [7:0]  timeout_cnt_o,
  output logic        overflow_o,
  output logic        slow_lost_o,
  input  logic        clr_i,
  output logic [1:0]  state_o
);

  localparam int unsigned DW   = 12;
  localparam int unsigned IDW  = 8;
  localparam int unsigned SDW  = 16;
  localparam int unsigned CNTW = 8;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned CW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RX   = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [DW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_cm_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              r_bad;
  logic              r_kind_slow;
  logic [IDW-1:0]    r_lat_id;
  logic [SDW-1:0]    r_lat_data;
  logic              r_slow_valid;
  logic [IDW-1:0]    r_slow_id;
  logic [SDW-1:0]    r_slow_data;
  logic [CNTW-1:0]   r_crc_err_cnt;
  logic [CNTW-1:0]   r_timeout_cnt;
  logic              r_overflow;
  logic              r_slow_lost;
  logic [CW-1:0]     r_idle_cnt;

  logic [PW-1:0]     w_total;
  logic              w_full;
  logic              w_fast_valid;
  logic              w_pop;
  logic              w_activity;
  logic              w_idle_hit;
  logic              w_wr_req;
  logic              w_do_write;
  logic              w_ovf_set;
  logic              w_rollback;
  logic              w_commit;
  logic              w_slow_commit;
  logic              w_latch;
  logic              w_crc_err;
  logic              w_timeout;
  logic              w_clr_bad;
  logic              w_lost_set;

  // Occupancy is judged on registered pointers, so a same-cycle pop frees no space yet.
  assign w_total      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_total == PW'(DEPTH));
  assign w_fast_valid = (r_cm_ptr != r_rd_ptr);
  assign w_pop        = w_fast_valid & fast_ready_i;
  assign w_activity   = start_i | wr_en_i | (done_pre_data_i != 3'b000) | crc_valid_i;
  assign w_idle_hit   = (r_idle_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_do_write   = w_wr_req & ~w_full;
  assign w_ovf_set    = w_wr_req & w_full;
  assign w_lost_set   = w_slow_commit & r_slow_valid & ~slow_ready_i;

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) r_state <= ST_IDLE;
    else             r_state <= w_next_state;
  end

  // Next state and per-cycle frame actions.
  always_comb begin
    w_next_state  = r_state;
    w_wr_req      = 1'b0;
    w_rollback    = 1'b0;
    w_commit      = 1'b0;
    w_slow_commit = 1'b0;
    w_latch       = 1'b0;
    w_crc_err     = 1'b0;
    w_timeout     = 1'b0;
    w_clr_bad     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_next_state = ST_RX;
      end
      ST_RX: begin
        if (start_i) begin
          w_rollback = 1'b1;
          w_clr_bad  = 1'b1;
        end else begin
          w_wr_req = wr_en_i;
          if (done_pre_data_i != 3'b000) begin
            w_latch      = 1'b1;
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (crc_valid_i) begin
          w_clr_bad    = 1'b1;
          w_next_state = ST_RX;
          if (crc_ok_i && !r_bad) begin
            if (r_kind_slow) begin
              w_slow_commit = 1'b1;
              w_rollback    = 1'b1;
            end else begin
              w_commit = 1'b1;
            end
          end else begin
            w_rollback = 1'b1;
            w_crc_err  = ~crc_ok_i;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && !w_activity && w_idle_hit) begin
      w_timeout    = 1'b1;
      w_rollback   = 1'b1;
      w_clr_bad    = 1'b1;
      w_next_state = ST_IDLE;
    end
  end

  // Buffer storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk_rx) begin
    if (w_do_write) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_bad       <= 1'b0;
      r_kind_slow <= 1'b0;
      r_lat_id    <= '0;
      r_lat_data  <= '0;
      r_idle_cnt  <= '0;
    end else begin
      if (w_rollback)      r_wr_ptr <= r_cm_ptr;
      else if (w_do_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_commit) r_cm_ptr <= r_wr_ptr;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_clr_bad)      r_bad <= 1'b0;
      else if (w_ovf_set) r_bad <= 1'b1;
      if (w_latch) begin
        r_kind_slow <= done_pre_data_i[2];
        if (done_pre_data_i[2]) begin
          r_lat_id   <= slow_id_i;
          r_lat_data <= slow_data_i;
        end
      end
      if ((r_state == ST_IDLE) || w_activity || w_timeout) r_idle_cnt <= '0;
      else                                                 r_idle_cnt <= r_idle_cnt + CW'(1);
    end
  end

  // Slow message holding register: a fresh commit overwrites an unconsumed one.
  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      r_slow_valid <= 1'b0;
      r_slow_id    <= '0;
      r_slow_data  <= '0;
    end else if (w_slow_commit) begin
      r_slow_valid <= 1'b1;
      r_slow_id    <= r_lat_id;
      r_slow_data  <= r_lat_data;
    end else if (slow_ready_i) begin
      r_slow_valid <= 1'b0;
    end
  end

  // Saturating counters and sticky flags; a same-cycle event beats clr_i.
  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      r_crc_err_cnt <= '0;
      r_timeout_cnt <= '0;
      r_overflow    <= 1'b0;
      r_slow_lost   <= 1'b0;
    end else begin
      if (w_crc_err) begin
        if (clr_i)                        r_crc_err_cnt <= CNTW'(1);
        else if (r_crc_err_cnt != '1)     r_crc_err_cnt <= r_crc_err_cnt + CNTW'(1);
      end else if (clr_i) begin
        r_crc_err_cnt <= '0;
      end
      if (w_timeout) begin
        if (clr_i)                        r_timeout_cnt <= CNTW'(1);
        else if (r_timeout_cnt != '1)     r_timeout_cnt <= r_timeout_cnt + CNTW'(1);
      end else if (clr_i) begin
        r_timeout_cnt <= '0;
      end
      r_overflow  <= (r_overflow  & ~clr_i) | w_ovf_set;
      r_slow_lost <= (r_slow_lost & ~clr_i) | w_lost_set;
    end
  end

  assign fast_valid_o  = w_fast_valid;
  assign fast_data_o   = w_fast_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign slow_valid_o  = r_slow_valid;
  assign slow_id_o     = r_slow_id;
  assign slow_data_o   = r_slow_data;
  assign crc_err_cnt_o = r_crc_err_cnt;
  assign timeout_cnt_o = r_timeout_cnt;
  assign overflow_o    = r_overflow;
  assign slow_lost_o   = r_slow_lost;
  assign state_o       = r_state;

endmodule

// File: tb/tb_sent_rx_frame_ctrl.sv
// Bench for sent_rx_frame_ctrl: directed vector table, hand sequences for timeout and
// reset, then randomized traffic against a queue-based reference model.
module tb_sent_rx_frame_ctrl;

  localparam int unsigned TO    = 16;
  localparam int unsigned DEPTH = 4;

  logic        clk_rx = 1'b0;
  logic        reset_n_rx;
  logic        start_i, wr_en_i, crc_valid_i, crc_ok_i;
  logic [11:0] wr_data_i;
  logic [2:0]  done_pre_data_i;
  logic [7:0]  slow_id_i;
  logic [15:0] slow_data_i;
  logic        fast_valid_o, fast_ready_i, slow_valid_o, slow_ready_i;
  logic [11:0] fast_data_o;
  logic [7:0]  slow_id_o, crc_err_cnt_o, timeout_cnt_o;
  logic [15:0] slow_data_o;
  logic        overflow_o, slow_lost_o, clr_i;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  sent_rx_frame_ctrl #(.TIMEOUT_CYC(TO), .DEPTH(DEPTH)) dut (
    .clk_rx(clk_rx), .reset_n_rx(reset_n_rx),
    .start_i(start_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .done_pre_data_i(done_pre_data_i), .crc_valid_i(crc_valid_i), .crc_ok_i(crc_ok_i),
    .slow_id_i(slow_id_i), .slow_data_i(slow_data_i),
    .fast_valid_o(fast_valid_o), .fast_data_o(fast_data_o), .fast_ready_i(fast_ready_i),
    .slow_valid_o(slow_valid_o), .slow_id_o(slow_id_o), .slow_data_o(slow_data_o),
    .slow_ready_i(slow_ready_i), .crc_err_cnt_o(crc_err_cnt_o), .timeout_cnt_o(timeout_cnt_o),
    .overflow_o(overflow_o), .slow_lost_o(slow_lost_o), .clr_i(clr_i), .state_o(state_o)
  );

  always #5 clk_rx = ~clk_rx;

  typedef struct packed {
    logic        start, wr;
    logic [11:0] data;
    logic [2:0]  done;
    logic        crcv, crcok;
    logic [7:0]  sid;
    logic [15:0] sdat;
    logic        fready, sready, clr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [1:0]  st;
    logic        fv;
    logic [11:0] fd;
    logic        sv;
    logic [7:0]  sid;
    logic [15:0] sdat;
    logic [7:0]  cec, toc;
    logic        ovf, lost;
  } vec_t;

  vec_t tbl[$];

  function automatic stim_t s_nop();
    stim_t s;
    s = '0;
    return s;
  endfunction
  function automatic stim_t s_start();
    stim_t s;
    s = '0; s.start = 1'b1;
    return s;
  endfunction
  function automatic stim_t s_wr(input logic [11:0] d);
    stim_t s;
    s = '0; s.wr = 1'b1; s.data = d;
    return s;
  endfunction
  function automatic stim_t s_done(input logic [2:0] d, input logic [7:0] id, input logic [15:0] dat);
    stim_t s;
    s = '0; s.done = d; s.sid = id; s.sdat = dat;
    return s;
  endfunction
  function automatic stim_t s_crc(input logic ok);
    stim_t s;
    s = '0; s.crcv = 1'b1; s.crcok = ok;
    return s;
  endfunction
  function automatic stim_t s_rdy(input stim_t si, input logic fr, input logic sr, input logic c);
    stim_t s;
    s = si; s.fready = fr; s.sready = sr; s.clr = c;
    return s;
  endfunction

  task automatic add(input stim_t s, input logic [1:0] st, input logic fv, input logic [11:0] fd,
                     input logic sv, input logic [7:0] sid, input logic [15:0] sdat,
                     input logic [7:0] cec, input logic [7:0] toc, input logic ovf, input logic lost);
    vec_t v;
    v.s = s; v.st = st; v.fv = fv; v.fd = fd; v.sv = sv; v.sid = sid; v.sdat = sdat;
    v.cec = cec; v.toc = toc; v.ovf = ovf; v.lost = lost;
    tbl.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    start_i = s.start; wr_en_i = s.wr; wr_data_i = s.data; done_pre_data_i = s.done;
    crc_valid_i = s.crcv; crc_ok_i = s.crcok; slow_id_i = s.sid; slow_data_i = s.sdat;
    fast_ready_i = s.fready; slow_ready_i = s.sready; clr_i = s.clr;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input int idx, input logic [1:0] st, input logic fv,
                         input logic [11:0] fd, input logic sv, input logic [7:0] sid,
                         input logic [15:0] sdat, input logic [7:0] cec, input logic [7:0] toc,
                         input logic ovf, input logic lost);
    chk({tag, ".state"},      idx, 32'(state_o),       32'(st));
    chk({tag, ".fast_valid"}, idx, 32'(fast_valid_o),  32'(fv));
    chk({tag, ".fast_data"},  idx, 32'(fast_data_o),   32'(fd));
    chk({tag, ".slow_valid"}, idx, 32'(slow_valid_o),  32'(sv));
    if (sv) begin
      chk({tag, ".slow_id"},   idx, 32'(slow_id_o),   32'(sid));
      chk({tag, ".slow_data"}, idx, 32'(slow_data_o), 32'(sdat));
    end
    chk({tag, ".crc_err_cnt"}, idx, 32'(crc_err_cnt_o), 32'(cec));
    chk({tag, ".timeout_cnt"}, idx, 32'(timeout_cnt_o), 32'(toc));
    chk({tag, ".overflow"},    idx, 32'(overflow_o),    32'(ovf));
    chk({tag, ".slow_lost"},   idx, 32'(slow_lost_o),   32'(lost));
  endtask

  // Reference model: committed and pending words as queues, frame state as a small int.
  int          m_st;
  logic [11:0] m_com[$];
  logic [11:0] m_unc[$];
  bit          m_bad, m_kind_slow, m_sv, m_ovf, m_lost;
  logic [7:0]  m_lat_id, m_sid;
  logic [15:0] m_lat_dat, m_sdat;
  int          m_cec, m_toc, m_silent;

  task automatic model_reset();
    m_st = 0; m_com.delete(); m_unc.delete(); m_bad = 0; m_kind_slow = 0; m_sv = 0;
    m_ovf = 0; m_lost = 0; m_lat_id = 0; m_sid = 0; m_lat_dat = 0; m_sdat = 0;
    m_cec = 0; m_toc = 0; m_silent = 0;
  endtask

  task automatic model_step(input stim_t s);
    bit act, pop, full, inc_crc, inc_to, ovf_set, slow_commit;
    int prev;
    act = s.start || s.wr || (s.done != 3'd0) || s.crcv;
    pop = (m_com.size() > 0) && s.fready;
    full = (m_com.size() + m_unc.size()) == int'(DEPTH);
    inc_crc = 0; inc_to = 0; ovf_set = 0; slow_commit = 0;
    prev = m_st;
    if (pop) void'(m_com.pop_front());
    case (prev)
      0: if (s.start) m_st = 1;
      1: begin
        if (s.start) begin
          m_unc.delete(); m_bad = 0;
        end else begin
          if (s.wr) begin
            if (full) begin ovf_set = 1; m_bad = 1; end
            else m_unc.push_back(s.data);
          end
          if (s.done != 3'd0) begin
            m_kind_slow = (s.done >= 3'd4);
            if (m_kind_slow) begin m_lat_id = s.sid; m_lat_dat = s.sdat; end
            m_st = 2;
          end
        end
      end
      default: begin
        if (s.crcv) begin
          if (s.crcok && !m_bad) begin
            if (!m_kind_slow) foreach (m_unc[i]) m_com.push_back(m_unc[i]);
            else slow_commit = 1;
          end else if (!s.crcok) inc_crc = 1;
          m_unc.delete(); m_bad = 0; m_st = 1;
        end
      end
    endcase
    if (prev != 0 && !act) begin
      if (m_silent == int'(TO) - 1) begin
        inc_to = 1; m_unc.delete(); m_bad = 0; m_st = 0; m_silent = 0;
      end else m_silent++;
    end else m_silent = 0;
    if (slow_commit) begin
      if (m_sv && !s.sready) m_lost = 1;
      else m_lost = m_lost & !s.clr;
      m_sv = 1; m_sid = m_lat_id; m_sdat = m_lat_dat;
      if (s.clr && !(m_sv && 0)) ;
    end else begin
      if (m_sv && s.sready) m_sv = 0;
      if (s.clr) m_lost = 0;
    end
    if (inc_crc) m_cec = s.clr ? 1 : ((m_cec < 255) ? m_cec + 1 : 255);
    else if (s.clr) m_cec = 0;
    if (inc_to) m_toc = s.clr ? 1 : ((m_toc < 255) ? m_toc + 1 : 255);
    else if (s.clr) m_toc = 0;
    m_ovf = (s.clr ? 1'b0 : m_ovf) | ovf_set;
  endtask

  task automatic step_check(input string tag, input int idx, input stim_t s);
    logic [11:0] fd;
    drive(s);
    model_step(s);
    @(posedge clk_rx); #1;
    fd = (m_com.size() > 0) ? m_com[0] : 12'h000;
    cmp_all(tag, idx, 2'(m_st), m_com.size() > 0, fd, m_sv, m_sid, m_sdat,
            8'(m_cec), 8'(m_toc), m_ovf, m_lost);
  endtask

  initial begin
    stim_t s;
    int quiet;
    reset_n_rx = 1'b0;
    drive(s_nop());
    repeat (2) @(posedge clk_rx);
    #1;
    cmp_all("reset", 0, 2'b00, 1'b0, 12'h0, 1'b0, 8'h0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);
    reset_n_rx = 1'b1;

    // idle ignores writes, done codes and crc verdicts
    add(s_nop(),                 2'd0, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_wr(12'hABC),           2'd0, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_done(3'b001, 0, 0),    2'd0, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_crc(1'b0),             2'd0, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    // good fast frame, then pop both words
    add(s_start(),               2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_wr(12'hABC),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_wr(12'h123),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_done(3'b001, 0, 0),    2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_crc(1'b1),             2'd1, 1, 12'hABC, 0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_rdy(s_nop(), 1, 0, 0), 2'd1, 1, 12'h123, 0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_rdy(s_nop(), 1, 0, 0), 2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    // bad crc frame
    add(s_wr(12'hABC),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_wr(12'h123),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_done(3'b001, 0, 0),    2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_crc(1'b0),             2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_nop(),                 2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    // five writes into a depth-4 buffer
    for (int i = 1; i <= 4; i++)
      add(s_wr(12'(i)),          2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_wr(12'h005),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);
    add(s_done(3'b010, 0, 0),    2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);
    add(s_crc(1'b1),             2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);
    add(s_rdy(s_nop(), 0, 0, 1), 2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    // slow messages, overwrite without ready
    add(s_done(3'b101, 8'h5A, 16'h1234), 2'd2, 0, 12'h0, 0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 0);
    add(s_crc(1'b1),             2'd1, 0, 12'h0,   1, 8'h5A, 16'h1234, 8'd0, 8'd0, 0, 0);
    add(s_nop(),                 2'd1, 0, 12'h0,   1, 8'h5A, 16'h1234, 8'd0, 8'd0, 0, 0);
    add(s_done(3'b100, 8'h77, 16'hBEEF), 2'd2, 0, 12'h0, 1, 8'h5A, 16'h1234, 8'd0, 8'd0, 0, 0);
    add(s_crc(1'b1),             2'd1, 0, 12'h0,   1, 8'h77, 16'hBEEF, 8'd0, 8'd0, 0, 1);
    add(s_rdy(s_nop(), 0, 1, 0), 2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 1);
    // clear coinciding with a crc error leaves the counter at 1
    add(s_done(3'b001, 0, 0),    2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd0, 8'd0, 0, 1);
    add(s_rdy(s_crc(1'b0), 0, 0, 1), 2'd1, 0, 12'h0, 0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    // crc outside WAIT ignored; restart drops pending; WAIT ignores writes and start
    add(s_crc(1'b0),             2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_wr(12'h111),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_start(),               2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_done(3'b001, 0, 0),    2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_wr(12'h222),           2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_start(),               2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_crc(1'b1),             2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    // full buffer: a same-cycle pop does not make room for the write
    add(s_wr(12'h0A1),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_wr(12'h0A2),           2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_done(3'b001, 0, 0),    2'd2, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_crc(1'b1),             2'd1, 1, 12'h0A1, 0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_wr(12'h0B1),           2'd1, 1, 12'h0A1, 0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_wr(12'h0B2),           2'd1, 1, 12'h0A1, 0, 8'h0, 16'h0, 8'd1, 8'd0, 0, 0);
    add(s_rdy(s_wr(12'h0B3), 1, 0, 0), 2'd1, 1, 12'h0A2, 0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);
    add(s_done(3'b001, 0, 0),    2'd2, 1, 12'h0A2, 0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);
    add(s_crc(1'b1),             2'd1, 1, 12'h0A2, 0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);
    add(s_rdy(s_nop(), 1, 0, 0), 2'd1, 0, 12'h0,   0, 8'h0, 16'h0, 8'd1, 8'd0, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].s);
      @(posedge clk_rx); #1;
      cmp_all("tbl", i, tbl[i].st, tbl[i].fv, tbl[i].fd, tbl[i].sv, tbl[i].sid, tbl[i].sdat,
              tbl[i].cec, tbl[i].toc, tbl[i].ovf, tbl[i].lost);
    end

    // inactivity timeout: start, then TO silent cycles
    drive(s_start());
    @(posedge clk_rx); #1;
    chk("to.start_state", 0, 32'(state_o), 32'd1);
    drive(s_nop());
    for (int i = 1; i <= int'(TO); i++) begin
      @(posedge clk_rx); #1;
      chk("to.state", i, 32'(state_o), (i == int'(TO)) ? 32'd0 : 32'd1);
      chk("to.count", i, 32'(timeout_cnt_o), (i == int'(TO)) ? 32'd1 : 32'd0);
    end
    chk("to.fast_valid", 0, 32'(fast_valid_o), 32'd0);
    chk("to.slow_valid", 0, 32'(slow_valid_o), 32'd0);

    // reset with committed words pending
    drive(s_start());       @(posedge clk_rx); #1;
    drive(s_wr(12'h005));   @(posedge clk_rx); #1;
    drive(s_wr(12'h006));   @(posedge clk_rx); #1;
    drive(s_done(3'b001, 0, 0)); @(posedge clk_rx); #1;
    drive(s_crc(1'b1));     @(posedge clk_rx); #1;
    drive(s_nop());
    chk("rst.pre_valid", 0, 32'(fast_valid_o), 32'd1);
    chk("rst.pre_data",  0, 32'(fast_data_o),  32'h005);
    #1 reset_n_rx = 1'b0;
    #1;
    cmp_all("rst", 0, 2'b00, 1'b0, 12'h0, 1'b0, 8'h0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(posedge clk_rx); #1;
    reset_n_rx = 1'b1;
    model_reset();
    @(posedge clk_rx); #1;
    cmp_all("rst.after", 0, 2'b00, 1'b0, 12'h0, 1'b0, 8'h0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);

    // randomized traffic against the model
    quiet = 0;
    for (int n = 0; n < 4000; n++) begin
      s = '0;
      s.fready = ($urandom_range(0, 99) < 45);
      s.sready = ($urandom_range(0, 99) < 35);
      s.clr    = ($urandom_range(0, 99) < 2);
      s.sid    = 8'($urandom);
      s.sdat   = 16'($urandom);
      if (quiet > 0) begin
        quiet--;
      end else if ($urandom_range(0, 99) < 2) begin
        quiet = $urandom_range(8, 24);
      end else begin
        s.start = ($urandom_range(0, 99) < 3);
        s.wr    = ($urandom_range(0, 99) < 30);
        s.data  = 12'($urandom);
        if ($urandom_range(0, 99) < 10) s.done = 3'($urandom_range(1, 5));
        s.crcv  = ($urandom_range(0, 99) < 12);
        s.crcok = ($urandom_range(0, 99) < 80);
      end
      step_check("rnd", n, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sent_rx_frame_ctrl.md
SENT_RX_FRAME_CTRL -- requirements
Module: sent_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 4096, inactivity cycles before a frame is abandoned.
REQ-002 SHALL have parameter DEPTH, default 4, fast-data buffer entries (power of 2).
REQ-003 SHALL have port clk_rx  in  1  rx clock.
REQ-004 SHALL have port reset_n_rx  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports start_i  in  1, wr_en_i  in  1, wr_data_i  in  12: pulse decoder frame start and fast-word write.
REQ-006 SHALL have port done_pre_data_i  in  3: frame-complete code, 001/010/011 = fast, 100/101 = slow, 000 = none.
REQ-007 SHALL have ports crc_valid_i  in  1 and crc_ok_i  in  1: CRC checker verdict, valid for one cycle.
REQ-008 SHALL have ports slow_id_i  in  8 and slow_data_i  in  16: decoded slow-channel message.
REQ-009 SHALL have ports fast_valid_o  out  1, fast_data_o  out  12, fast_ready_i  in  1: committed fast-word stream.
REQ-010 SHALL have ports slow_valid_o  out  1, slow_id_o  out  8, slow_data_o  out  16, slow_ready_i  in  1: committed slow message.
REQ-011 SHALL have ports crc_err_cnt_o  out  8, timeout_cnt_o  out  8, overflow_o  out  1, slow_lost_o  out  1, clr_i  in  1, state_o  out  2.

Function
REQ-012 SHALL implement states IDLE=00, RX_FRAME=01, WAIT_CRC=10, reported on state_o.
REQ-013 IDLE SHALL go to RX_FRAME on start_i; wr_en_i and done_pre_data_i SHALL be ignored in IDLE.
REQ-014 RX_FRAME SHALL store wr_data_i into the buffer as an uncommitted entry on each wr_en_i.
REQ-015 RX_FRAME SHALL go to WAIT_CRC on non-zero done_pre_data_i, recording kind FAST (001/010/011) or SLOW (100/101); for SLOW it SHALL latch slow_id_i/slow_data_i the same cycle.
REQ-016 In WAIT_CRC, further done_pre_data_i and wr_en_i SHALL be ignored (write dropped, not counted as overflow).
REQ-017 On crc_valid_i in WAIT_CRC with crc_ok_i=1 and no overflow this frame: FAST SHALL commit all uncommitted entries; SLOW SHALL present the latched message; next state RX_FRAME.
REQ-018 On crc_valid_i in WAIT_CRC with crc_ok_i=0 or frame overflow: uncommitted entries SHALL be discarded (write pointer rolled back to commit pointer), crc_err_cnt_o incremented (only if crc_ok_i=0), next state RX_FRAME.
REQ-019 crc_valid_i outside WAIT_CRC SHALL be ignored.
REQ-020 Commit/rollback SHALL take effect the cycle after crc_valid_i; fast_valid_o SHALL rise no earlier than that cycle.
REQ-021 fast_valid_o SHALL be 1 iff committed count > 0; fast_data_o SHALL be oldest committed entry; pop on fast_valid_o & fast_ready_i.
REQ-022 A write when total (committed+uncommitted) = DEPTH SHALL be dropped, set overflow_o (sticky) and mark the frame bad.
REQ-023 Simultaneous pop and write SHALL both occur; a pop frees space for a write in the same cycle only from the next cycle onward.
REQ-024 slow_valid_o SHALL hold with stable slow_id_o/slow_data_o until slow_ready_i; a new slow commit while slow_valid_o=1 and not popping SHALL overwrite and set slow_lost_o (sticky).
REQ-025 Inactivity counter SHALL reset on start_i, wr_en_i, non-zero done_pre_data_i or crc_valid_i, and count in RX_FRAME/WAIT_CRC only.
REQ-026 Counter reaching TIMEOUT_CYC-1 SHALL roll back uncommitted entries, increment timeout_cnt_o, go to IDLE.
REQ-027 start_i in RX_FRAME SHALL restart the frame: uncommitted entries rolled back, stay RX_FRAME; start_i in WAIT_CRC SHALL be ignored.
REQ-028 Counters SHALL saturate at 255; clr_i SHALL zero both counters and both sticky flags, lower priority than same-cycle increment (counter becomes 1).

Reset
REQ-029 Reset SHALL force IDLE, empty buffer with both pointers 0, all outputs 0, counters 0, sticky flags 0, inactivity counter 0.
REQ-030 Reset mid-frame SHALL discard all buffered data, committed included.

Verification
REQ-031 start, writes 0xABC,0x123, done=001, crc_ok=1 -> fast_valid next cycle, pops 0xABC then 0x123, state 01.
REQ-032 Same frame with crc_ok=0 -> no fast_valid, crc_err_cnt_o=1, buffer empty.
REQ-033 fast_ready_i=0, 5 writes with DEPTH=4 -> overflow_o=1, frame discarded even with crc_ok=1.
REQ-034 done=101, slow_id=0x5A, slow_data=0x1234, crc_ok=1 -> slow_valid_o with those values until slow_ready_i; second commit without ready -> slow_lost_o=1.
REQ-035 start then silence TIMEOUT_CYC cycles -> timeout_cnt_o=1, state 00, no valid output.
REQ-036 Assert reset_n_rx with committed entries pending -> fast_valid_o=0 immediately, all counters 0.
